alu_cmd_checker: RTL and testbench
==================================

Name: alu_cmd_checker

Overview:
- Hardware initiator for the combinational 4-bit ALU; it is the driving side of the ALU's op/in_x/in_y → out_s/out_c/zero/overflow interface.
- Accepts one command per valid/ready handshake carrying op, operands and the expected result and flags.
- Drives the ALU, waits a fixed settle time, then captures the ALU outputs and compares them with the expected values.
- Returns a response carrying the captured values and a mismatch mask, and keeps a saturating error counter. Used for on-chip ALU self-test and for sequencing ALU operations from a controller.

Parameters:
- WIDTH, 4, ALU operand/result width.
- SETTLE_CYCLES, 2, clock cycles ALU inputs are held before sampling; must be >= 1 (elaboration error otherwise).
- CNT_W, 16, width of err_count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  ALU op code.
- cmd_x  in  WIDTH  operand x.
- cmd_y  in  WIDTH  operand y.
- cmd_exp_s  in  WIDTH  expected result.
- cmd_exp_flags  in  3  expected {overflow, carry, zero}.
- alu_op  out  3  to ALU op.
- alu_x  out  WIDTH  to ALU in_x.
- alu_y  out  WIDTH  to ALU in_y.
- alu_s  in  WIDTH  from ALU out_s.
- alu_c  in  1  from ALU out_c.
- alu_zero  in  1  from ALU zero.
- alu_overflow  in  1  from ALU overflow.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_s  out  WIDTH  captured result.
- rsp_flags  out  3  captured {overflow, carry, zero}.
- rsp_mismatch  out  4  {s, overflow, carry, zero}; a bit is 1 where captured != expected.
- err_count  out  CNT_W  number of responses with a nonzero mismatch, saturating.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: state IDLE; alu_op, alu_x, alu_y = 0; rsp_s, rsp_flags, rsp_mismatch = 0; rsp_valid = 0; err_count = 0; busy = 0.
- cmd_ready = (state == IDLE), combinational from state only. It reads 1 while rst is high.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - On cmd_valid & cmd_ready at edge N: register cmd_op/x/y onto alu_op/x/y, register the expected values internally, load the settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - Counter decrements each cycle.
  - On the edge where the counter == 0 (edge N+SETTLE_CYCLES): sample alu_s/c/zero/overflow into rsp_s and rsp_flags.
  - On the same edge, compute rsp_mismatch from the sampled values against the registered expected values, and set rsp_valid = 1.
  - On the same edge, if the mismatch is nonzero, increment err_count; it holds at all-ones once reached.
  - Go to RESP.
- RESP:
  - rsp_* are held stable while rsp_valid & !rsp_ready.
  - On rsp_valid & rsp_ready: clear rsp_valid and go to IDLE. No command is accepted on that same edge.
- Latency and throughput:
  - Accept at edge N; rsp_valid visible after edge N+SETTLE_CYCLES.
  - With rsp_ready held high, minimum command spacing is SETTLE_CYCLES+2 cycles.
- alu_op/x/y hold their last command values after completion; they do not return to 0.
- rsp_s/flags/mismatch keep their last values after the handshake.
- cmd_* values are ignored outside the accept cycle. Undefined op codes 7 are passed through unchanged; the checker does not interpret op.
- Reset mid-operation: the command is aborted immediately, no response is produced, err_count is cleared, and all outputs take their reset values.
- err_count is never cleared other than by reset.

Decomposition:
- Package alu_pkg:
  - op-code constants ADD=0, SUB=1, NOT=2, AND=3, OR=4, XOR=5, SLT=6;
  - flag bit indices FLAG_OF=2, FLAG_C=1, FLAG_Z=0;
  - mismatch bit indices MM_S=3, MM_OF=2, MM_C=1, MM_Z=0;
  - state enum for IDLE/SETTLE/RESP.
- Sub-module alu_result_compare: purely combinational; takes captured and expected result plus flags and produces the 4-bit mismatch mask. It is shared with future ALU checkers.

Test Plan (the bench instantiates the real ALU on the alu_* ports; SETTLE_CYCLES=2 unless stated):
1. Reset: assert rst → cmd_ready=1, rsp_valid=0, busy=0, err_count=0, alu_op/x/y=0 while rst is high and after release.
2. Correct add: op=0, x=0011, y=1101, exp_s=0000, exp_flags=011, accepted at edge N → rsp_valid rises after edge N+2, rsp_s=0000, rsp_flags=011, rsp_mismatch=0000, err_count=0.
3. Wrong expectation: op=1, x=1000, y=0001, exp_s=0000, exp_flags=000 → rsp_s=0111, rsp_flags=110, rsp_mismatch=1110, err_count=1.
4. Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 → rsp_valid=1 and rsp_* stable, cmd_ready=0, no second accept. Raise rsp_ready → handshake, then cmd_ready=1 on the next cycle and the next command is accepted.
5. Reset mid-SETTLE: accept op=3, x=1100, y=0011, then pulse rst one cycle later → rsp_valid never asserts, err_count=0, cmd_ready=1.
6. Saturation, CNT_W=2: four mismatching commands → err_count goes 1, 2, 3, 3.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, flag/mismatch bit positions and checker states
package alu_pkg;
  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] NOT = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] OR  = 3'd4;
  localparam logic [2:0] XOR = 3'd5;
  localparam logic [2:0] SLT = 3'd6;
  localparam int FLAG_OF = 2;
  localparam int FLAG_C  = 1;
  localparam int FLAG_Z  = 0;
  localparam int MM_S  = 3;
  localparam int MM_OF = 2;
  localparam int MM_C  = 1;
  localparam int MM_Z  = 0;
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
endpackage

// File: rtl/alu_result_compare.sv
// alu_result_compare: per-field mismatch mask between captured and expected ALU results
module alu_result_compare import alu_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cap_s,
  input  logic [2:0]       cap_flags,
  input  logic [WIDTH-1:0] exp_s,
  input  logic [2:0]       exp_flags,
  output logic [3:0]       mismatch
);
  assign mismatch[MM_S]  = cap_s != exp_s;
  assign mismatch[MM_OF] = cap_flags[FLAG_OF] != exp_flags[FLAG_OF];
  assign mismatch[MM_C]  = cap_flags[FLAG_C] != exp_flags[FLAG_C];
  assign mismatch[MM_Z]  = cap_flags[FLAG_Z] != exp_flags[FLAG_Z];
endmodule

// File: rtl/alu_cmd_checker.sv
// alu_cmd_checker: drives the ALU per command, samples after a settle time and reports mismatches
module alu_cmd_checker import alu_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_x,
  input  logic [WIDTH-1:0] cmd_y,
  input  logic [WIDTH-1:0] cmd_exp_s,
  input  logic [2:0]       cmd_exp_flags,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_c,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic [2:0]       rsp_flags,
  output logic [3:0]       rsp_mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] exp_s_q;
  logic [2:0]       exp_flags_q;
  logic [2:0]       alu_flags;
  logic [3:0]       mm;
  assign alu_flags = {alu_overflow, alu_c, alu_zero};
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  alu_result_compare #(.WIDTH(WIDTH)) u_cmp (
    .cap_s(alu_s),
    .cap_flags(alu_flags),
    .exp_s(exp_s_q),
    .exp_flags(exp_flags_q),
    .mismatch(mm)
  );
  // The compare runs on live ALU outputs so the mask is ready on the sampling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      exp_s_q <= '0;
      exp_flags_q <= '0;
      alu_op <= '0;
      alu_x <= '0;
      alu_y <= '0;
      rsp_valid <= 1'b0;
      rsp_s <= '0;
      rsp_flags <= '0;
      rsp_mismatch <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          alu_op <= cmd_op;
          alu_x <= cmd_x;
          alu_y <= cmd_y;
          exp_s_q <= cmd_exp_s;
          exp_flags_q <= cmd_exp_flags;
          cnt <= CW'(SETTLE_CYCLES - 1);
          state <= SETTLE;
        end
        SETTLE: if (cnt == '0) begin
          rsp_s <= alu_s;
          rsp_flags <= alu_flags;
          rsp_mismatch <= mm;
          rsp_valid <= 1'b1;
          if (|mm && !(&err_count)) err_count <= err_count + 1'b1;
          state <= RESP;
        end else cnt <= cnt - 1'b1;
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_checker.sv
// tb_alu_cmd_checker: random and directed checks of alu_cmd_checker against a behavioural ALU and response model
module tb_alu_cmd_checker;
  localparam int SETTLE = 2;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, rsp_ready = 0;
  logic [2:0] cmd_op = 0, cmd_exp_flags = 0;
  logic [3:0] cmd_x = 0, cmd_y = 0, cmd_exp_s = 0;
  logic cmd_ready, rsp_valid, busy, alu_c, alu_zero, alu_overflow;
  logic [2:0] alu_op, rsp_flags;
  logic [3:0] alu_x, alu_y, alu_s, rsp_s, rsp_mismatch;
  logic [15:0] err_count;
  logic cmd_ready2, rsp_valid2, busy2, alu_c2, alu_zero2, alu_overflow2;
  logic [2:0] alu_op2, rsp_flags2;
  logic [3:0] alu_x2, alu_y2, alu_s2, rsp_s2, rsp_mismatch2;
  logic [1:0] err_count2;
  int n_cmp = 0, n_err = 0, err_exp = 0;

  always #5 clk = ~clk;

  // Behavioural 4-bit ALU: returns {overflow, carry, zero, s}
  function automatic logic [6:0] alu_ref(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    int ux = int'(x), uy = int'(y);
    int sx = int'($signed(x)), sy = int'($signed(y));
    int r = 0;
    logic c = 0, v = 0;
    case (op)
      3'd0: begin r = ux + uy; c = r > 15; v = (sx + sy) > 7 || (sx + sy) < -8; end
      3'd1: begin r = ux - uy; c = ux >= uy; v = (sx - sy) > 7 || (sx - sy) < -8; end
      3'd2: r = 15 - ux;
      3'd3: r = int'(x & y);
      3'd4: r = int'(x | y);
      3'd5: r = int'(x ^ y);
      3'd6: r = sx < sy ? 1 : 0;
      default: r = 0;
    endcase
    return {v, c, r[3:0] == 4'd0, r[3:0]};
  endfunction

  assign {alu_overflow, alu_c, alu_zero, alu_s} = alu_ref(alu_op, alu_x, alu_y);
  assign {alu_overflow2, alu_c2, alu_zero2, alu_s2} = alu_ref(alu_op2, alu_x2, alu_y2);

  alu_cmd_checker #(.WIDTH(4), .SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_exp_s(cmd_exp_s), .cmd_exp_flags(cmd_exp_flags),
    .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s), .alu_c(alu_c),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_flags(rsp_flags), .rsp_mismatch(rsp_mismatch), .err_count(err_count), .busy(busy)
  );

  alu_cmd_checker #(.WIDTH(4), .SETTLE_CYCLES(SETTLE), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_exp_s(cmd_exp_s), .cmd_exp_flags(cmd_exp_flags),
    .alu_op(alu_op2), .alu_x(alu_x2), .alu_y(alu_y2), .alu_s(alu_s2), .alu_c(alu_c2),
    .alu_zero(alu_zero2), .alu_overflow(alu_overflow2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s2), .rsp_flags(rsp_flags2), .rsp_mismatch(rsp_mismatch2), .err_count(err_count2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".err_count"}, 32'(err_count), 0);
    chk({tag, ".alu_opxy"}, {20'd0, alu_op, alu_x, alu_y, 1'b0}, 0);
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y,
                        input logic [3:0] es, input logic [2:0] ef, input int stall);
    logic [6:0] r;
    logic [3:0] mm;
    int k, lat, sat;
    r = alu_ref(op, x, y);
    mm = {r[3:0] != es, r[6] != ef[2], r[5] != ef[1], r[4] != ef[0]};
    cmd_valid = 1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_exp_s = es; cmd_exp_flags = ef;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    chk("accept_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 0; cmd_op = ~op; cmd_x = ~x; cmd_y = ~y; cmd_exp_s = ~es; cmd_exp_flags = ~ef;
    chk("busy_after_accept", 32'(busy), 1);
    chk("ready_after_accept", 32'(cmd_ready), 0);
    chk("alu_drive", {21'd0, alu_op, alu_x, alu_y}, {21'd0, op, x, y});
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("latency", lat, SETTLE);
    if (mm != 0) err_exp++;
    sat = err_exp > 3 ? 3 : err_exp;
    chk("rsp_s", 32'(rsp_s), 32'(r[3:0]));
    chk("rsp_flags", 32'(rsp_flags), 32'(r[6:4]));
    chk("rsp_mismatch", 32'(rsp_mismatch), 32'(mm));
    chk("err_count", 32'(err_count), err_exp);
    chk("err_count_sat", 32'(err_count2), sat);
    chk("rsp_valid_sat", 32'(rsp_valid2), 1);
    cmd_valid = 1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_ready", 32'(cmd_ready), 0);
      chk("stall_hold", {17'd0, rsp_s, rsp_flags, rsp_mismatch, alu_x}, {17'd0, r[3:0], r[6:4], mm, x});
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("hs_valid", 32'(rsp_valid), 0);
    chk("hs_ready", 32'(cmd_ready), 1);
    chk("hs_no_accept", {21'd0, alu_op, alu_x, alu_y}, {21'd0, op, x, y});
    chk("hs_keep", {21'd0, rsp_s, rsp_flags, rsp_mismatch}, {21'd0, r[3:0], r[6:4], mm});
    cmd_valid = 0; rsp_ready = 0;
  endtask

  initial begin
    logic [6:0] r;
    logic [3:0] es;
    logic [2:0] ef;
    repeat (2) @(negedge clk);
    chk_idle("reset_held");
    rst = 0;
    @(negedge clk);
    chk_idle("reset_released");
    do_cmd(3'd0, 4'b0011, 4'b1101, 4'b0000, 3'b011, 0);
    do_cmd(3'd1, 4'b1000, 4'b0001, 4'b0000, 3'b000, 0);
    do_cmd(3'd5, 4'b1010, 4'b0110, 4'b1100, 3'b000, 5);
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [3:0] x, y;
      op = 3'($urandom_range(0, 7)); x = 4'($urandom); y = 4'($urandom);
      r = alu_ref(op, x, y);
      if ($urandom_range(0, 1) == 1) begin es = r[3:0]; ef = r[6:4]; end
      else begin es = 4'($urandom); ef = 3'($urandom); end
      do_cmd(op, x, y, es, ef, $urandom_range(0, 3));
    end
    cmd_valid = 1; cmd_op = 3'd3; cmd_x = 4'b1100; cmd_y = 4'b0011; cmd_exp_s = 4'b1111; cmd_exp_flags = 3'b000;
    @(negedge clk);
    cmd_valid = 0;
    chk("abort_busy", 32'(busy), 1);
    @(negedge clk);
    rst = 1;
    #1;
    err_exp = 0;
    chk_idle("abort_in_reset");
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {30'd0, rsp_valid, rsp_valid2}, 0);
    end
    chk_idle("abort_after");
    for (int i = 0; i < 4; i++) begin
      r = alu_ref(3'd4, 4'(i), 4'(i + 3));
      do_cmd(3'd4, 4'(i), 4'(i + 3), ~r[3:0], r[6:4], 0);
    end
    chk("sat_final", 32'(err_count2), 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
